// File: rtl/orb_arb_pkg.sv
// ---------------------------------------------------------------------------
// orb_arb_pkg
//   Shared widths, slot-FSM state type and a small helper for the orbital
//   frame RAM write arbiter (orb_wr_arbiter, orb_rr_picker).
//   ADDR_W : frame RAM address width
//   DATA_W : frame RAM word width
//   CNT_W  : per-requester write statistics counter width
// ---------------------------------------------------------------------------
package orb_arb_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 12;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } arb_state_e;

    // Largest of three phase lengths; sizes the shared slot down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/orb_rr_picker.sv
// ---------------------------------------------------------------------------
// orb_rr_picker
//   Combinational round-robin picker: the winner is the first asserted
//   request found scanning upward from the pointer, wrapping modulo NREQ.
//   req        in  NREQ   request levels
//   ptr        in  PTR_W  scan start index (0..NREQ-1)
//   win_onehot out NREQ   one-hot winner (0 when no request)
//   win_idx    out PTR_W  winner index (0 when no request)
//   win_valid  out 1      at least one request asserted
// ---------------------------------------------------------------------------
module orb_rr_picker #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win_onehot,
    output logic [PTR_W-1:0] win_idx,
    output logic             win_valid
);

    int               cand;
    logic [PTR_W-1:0] cand_idx;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Wrap by subtraction; ptr is always < NREQ so one step suffices.
            cand = int'(ptr) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = PTR_W'(cand);
            if (!win_valid && req[cand_idx]) begin
                win_valid            = 1'b1;
                win_idx              = cand_idx;
                win_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/orb_wr_arbiter.sv
// ---------------------------------------------------------------------------
// orb_wr_arbiter
//   Shares the frame RAM write port between NREQ word producers. In IDLE a
//   round-robin winner is granted and its addr/word latched; a fixed slot of
//   SETUP_CYC + WE_CYC + HOLD_CYC cycles then drives the RAM, and the winner
//   gets a one-cycle ack in the last HOLD cycle.
//   clk       in   system clock (rising edge)
//   rst       in   asynchronous reset, active low
//   req       in   NREQ level requests
//   addr_bus  in   requester i address at [i*11 +: 11]
//   word_bus  in   requester i word at [i*12 +: 12]
//   ack       out  one-cycle slot-complete pulse per requester
//   grant     out  one-hot slot owner, 0 in IDLE
//   busy      out  high from SETUP through HOLD
//   WE        out  RAM write enable
//   WrAddr    out  RAM write address (held until next grant)
//   orbWord   out  RAM write data (held until next grant)
//   Optional (macro ORB_ARB_STATS_EN):
//   clr_stats in   synchronous clear of all write counters (beats increment)
//   wr_cnt    out  16-bit write count per requester at [i*16 +: 16]
// ---------------------------------------------------------------------------
module orb_wr_arbiter
    import orb_arb_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int SETUP_CYC = 13,
    parameter int WE_CYC    = 3,
    parameter int HOLD_CYC  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr_bus,
    input  logic [NREQ*DATA_W-1:0] word_bus,
`ifdef ORB_ARB_STATS_EN
    input  logic                   clr_stats,
    output logic [NREQ*CNT_W-1:0]  wr_cnt,
`endif
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   WE,
    output logic [ADDR_W-1:0]      WrAddr,
    output logic [DATA_W-1:0]      orbWord
);

    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SLOT_W = $clog2(max3(SETUP_CYC, WE_CYC, HOLD_CYC) + 1);

    // Each phase counts down to zero, so the load value is length-1.
    localparam logic [SLOT_W-1:0] SETUP_LOAD = SLOT_W'(SETUP_CYC - 1);
    localparam logic [SLOT_W-1:0] WE_LOAD    = SLOT_W'(WE_CYC - 1);
    localparam logic [SLOT_W-1:0] HOLD_LOAD  = SLOT_W'(HOLD_CYC - 1);

    arb_state_e        state_q, state_d;
    logic [SLOT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] orb_word_q, orb_word_d;

    logic [NREQ-1:0]   win_onehot;
    logic [PTR_W-1:0]  win_idx;
    logic              win_valid;

    logic [ADDR_W-1:0] addr_arr [NREQ];
    logic [DATA_W-1:0] word_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = addr_bus[gi*ADDR_W +: ADDR_W];
            assign word_arr[gi] = word_bus[gi*DATA_W +: DATA_W];
        end
    endgenerate

    orb_rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req        (req),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        wr_addr_d  = wr_addr_q;
        orb_word_d = orb_word_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d    = SETUP;
                    cnt_d      = SETUP_LOAD;
                    grant_d    = win_onehot;
                    wr_addr_d  = addr_arr[win_idx];
                    orb_word_d = word_arr[win_idx];
                    ptr_d      = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = WE_LOAD;
                end else begin
                    cnt_d = cnt_q - SLOT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - SLOT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q - SLOT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            ptr_q      <= '0;
            wr_addr_q  <= '0;
            orb_word_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            wr_addr_q  <= wr_addr_d;
            orb_word_q <= orb_word_d;
        end
    end

    // Outputs decode straight from the state flop so that WE falls the
    // instant reset is asserted, not at the next clock.
    assign WE      = (state_q == STROBE);
    assign busy    = (state_q != IDLE);
    assign grant   = grant_q;
    assign ack     = (state_q == HOLD && cnt_q == '0) ? grant_q : '0;
    assign WrAddr  = wr_addr_q;
    assign orbWord = orb_word_q;

`ifdef ORB_ARB_STATS_EN
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stats
            logic [CNT_W-1:0] cnt_stat_q, cnt_stat_d;

            always_comb begin
                cnt_stat_d = cnt_stat_q;
                if (clr_stats) begin
                    cnt_stat_d = '0;
                end else if (ack[gi]) begin
                    cnt_stat_d = cnt_stat_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_stat_q <= '0;
                end else begin
                    cnt_stat_q <= cnt_stat_d;
                end
            end

            assign wr_cnt[gi*CNT_W +: CNT_W] = cnt_stat_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_orb_wr_arbiter
//   Bench for orb_wr_arbiter with default parameters. The reference model
//   tracks each slot by its start cycle and derives every output from the
//   cycle offset within the slot. Directed scenarios pin the model with
//   literal expectations; a random phase exercises arbitration at large.
//   Define ORB_ARB_STATS_EN to also exercise the write counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_orb_wr_arbiter;

    localparam int NREQ     = 3;
    localparam int SETUP_C  = 13;
    localparam int WE_C     = 3;
    localparam int HOLD_C   = 15;
    localparam int WE_FIRST = 1 + SETUP_C;               // 14
    localparam int WE_LAST  = SETUP_C + WE_C;            // 16
    localparam int ACK_OFF  = SETUP_C + WE_C + HOLD_C;   // 31

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*11-1:0]   addr_bus;
    logic [NREQ*12-1:0]   word_bus;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 WE;
    logic [10:0]          WrAddr;
    logic [11:0]          orbWord;
`ifdef ORB_ARB_STATS_EN
    logic                 clr_stats;
    logic [NREQ*16-1:0]   wr_cnt;
`endif

    orb_wr_arbiter #(
        .NREQ      (NREQ),
        .SETUP_CYC (SETUP_C),
        .WE_CYC    (WE_C),
        .HOLD_CYC  (HOLD_C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr_bus  (addr_bus),
        .word_bus  (word_bus),
`ifdef ORB_ARB_STATS_EN
        .clr_stats (clr_stats),
        .wr_cnt    (wr_cnt),
`endif
        .ack       (ack),
        .grant     (grant),
        .busy      (busy),
        .WE        (WE),
        .WrAddr    (WrAddr),
        .orbWord   (orbWord)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;

    // Reference model: slot described by start cycle, winner and latched data.
    bit          m_active;
    int          m_t;
    int          m_win;
    int          m_ptr;
    logic [10:0] m_addr;
    logic [11:0] m_word;
    int          m_cnt [NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1 << i);
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_win    = 0;
        m_ptr    = 0;
        m_addr   = '0;
        m_word   = '0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    // Called at posedge+1 with this cycle's inputs already driven: compare
    // the outputs of this cycle, let the model consume the inputs, advance.
    task automatic step();
        int              off;
        logic [NREQ-1:0] e_grant;
        logic [NREQ-1:0] e_ack;
        bit              found;
        int              c;
        off     = m_active ? (cyc - m_t) : -1;
        e_grant = (off >= 1) ? oh(m_win) : '0;
        e_ack   = (off == ACK_OFF) ? oh(m_win) : '0;
        check("grant",   64'(grant),   64'(e_grant));
        check("ack",     64'(ack),     64'(e_ack));
        check("busy",    64'(busy),    64'(off >= 1));
        check("we",      64'(WE),      64'(off >= WE_FIRST && off <= WE_LAST));
        check("wraddr",  64'(WrAddr),  64'(m_addr));
        check("orbword", 64'(orbWord), 64'(m_word));
`ifdef ORB_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            check("wr_cnt", 64'(16'(wr_cnt >> (i*16))), 64'(m_cnt[i]));
        for (int i = 0; i < NREQ; i++) begin
            if (clr_stats) m_cnt[i] = 0;
            else if (off == ACK_OFF && m_win == i) m_cnt[i] = (m_cnt[i] + 1) % 65536;
        end
`endif
        if (off == ACK_OFF) begin
            m_active = 1'b0;
        end else if (!m_active && req != '0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!found && ((req >> c) & 1) != 0) begin
                    found = 1'b1;
                    m_win = c;
                end
            end
            m_active = 1'b1;
            m_t      = cyc;
            m_addr   = 11'(addr_bus >> (m_win*11));
            m_word   = 12'(word_bus >> (m_win*12));
            m_ptr    = (m_win + 1) % NREQ;
            $display("[TB] cyc %0d grant r%0d addr %03h word %03h", cyc, m_win, m_addr, m_word);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset asserted mid-cycle, released at posedge+1.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_we",    64'(WE),      64'd0);
        check("rst_grant", 64'(grant),   64'd0);
        check("rst_busy",  64'(busy),    64'd0);
        check("rst_ack",   64'(ack),     64'd0);
        check("rst_addr",  64'(WrAddr),  64'd0);
        check("rst_word",  64'(orbWord), 64'd0);
`ifdef ORB_ARB_STATS_EN
        check("rst_cnt",   64'(wr_cnt),  64'd0);
        clr_stats = 1'b0;
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
    endtask

    task automatic idle_out(input int n);
        req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_req_data(input int i, input logic [10:0] a, input logic [11:0] w);
        addr_bus[i*11 +: 11] = a;
        word_bus[i*12 +: 12] = w;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        addr_bus = '0;
        word_bus = '0;
`ifdef ORB_ARB_STATS_EN
        clr_stats = 1'b0;
`endif
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single write from requester 0.
        set_req_data(0, 11'h040, 12'h5A8);
        req = 3'b001;
        for (int k = 0; k <= 33; k++) begin
            if (k == 32) req = '0;
            if (k == 1) begin
                check("t1_addr",  64'(WrAddr),  64'h040);
                check("t1_word",  64'(orbWord), 64'h5A8);
                check("t1_grant", 64'(grant),   64'h1);
            end
            if (k == 13) check("t1_we_pre",  64'(WE), 64'd0);
            if (k == 14) check("t1_we_on",   64'(WE), 64'd1);
            if (k == 16) check("t1_we_last", 64'(WE), 64'd1);
            if (k == 17) check("t1_we_off",  64'(WE), 64'd0);
            if (k == 30) check("t1_ack_pre", 64'(ack), 64'd0);
            if (k == 31) check("t1_ack",     64'(ack), 64'h1);
            if (k == 32) check("t1_ack_end", 64'(ack), 64'd0);
            step();
        end

        // Contention: all three held from pointer 0.
        do_reset();
        set_req_data(1, 11'h123, 12'hABC);
        set_req_data(2, 11'h7FF, 12'h001);
        req = 3'b111;
        for (int k = 0; k <= 100; k++) begin
            if (k == 1)  check("t2_g0", 64'(grant), 64'h1);
            if (k == 32) check("t2_gap", 64'(busy), 64'd0);
            if (k == 33) check("t2_g1", 64'(grant), 64'h2);
            if (k == 65) check("t2_g2", 64'(grant), 64'h4);
            if (k == 97) check("t2_g3", 64'(grant), 64'h1);
            step();
        end
        idle_out(40);

        // Fairness: req2 raised mid-slot while req0 stays high.
        do_reset();
        req = 3'b001;
        for (int k = 0; k <= 40; k++) begin
            if (k == 10) req = 3'b101;
            if (k == 33) check("t3_fair", 64'(grant), 64'h4);
            step();
        end
        idle_out(70);

        // Drop: req1 removed at T+5, slot still completes.
        do_reset();
        set_req_data(1, 11'h2A5, 12'h3C3);
        req = 3'b010;
        for (int k = 0; k <= 32; k++) begin
            if (k == 5) req = '0;
            if (k == 14) check("t4_we",  64'(WE),  64'd1);
            if (k == 31) check("t4_ack", 64'(ack), 64'h2);
            step();
        end

        // Reset in the middle of the strobe.
        req = 3'b010;
        for (int k = 0; k < 15; k++) step();
        check("t5_we_before", 64'(WE), 64'd1);
        do_reset();
        req = 3'b111;
        step();
        check("t5_rearb", 64'(grant), 64'h1);
        idle_out(40);

`ifdef ORB_ARB_STATS_EN
        // Three writes from requester 0, then a clear on the fourth ack.
        do_reset();
        req = 3'b001;
        for (int k = 0; k <= 128; k++) begin
            clr_stats = (k == 127);
            if (k == 96)  check("t6_cnt3", 64'(wr_cnt[15:0]), 64'd3);
            if (k == 127) check("t6_ack",  64'(ack), 64'h1);
            if (k == 128) check("t6_clr",  64'(wr_cnt[15:0]), 64'd0);
            step();
        end
        clr_stats = 1'b0;
        idle_out(40);
`endif

        // Random traffic, with one asynchronous reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 3) == 0) set_req_data(i, 11'($urandom), 12'($urandom));
            end
`ifdef ORB_ARB_STATS_EN
            clr_stats = ($urandom_range(0, 63) == 0);
`endif
            if (n == 1500) do_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
